// File: rtl/ex_mem_pipeline_register.sv
// EX/MEM pipeline register: captures EX-stage control and datapath values for the MEM stage.
// Flush loads a bubble (all zeros) and takes priority over stall, which holds the contents.
module ex_mem_pipeline_register #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      EX_MEM_Flush,
    input  logic                      EX_MEM_Stall,
    input  logic                      EX_MemWre,
    output logic                      MEM_MemWre,
    input  logic                      EX_MemRead,
    output logic                      MEM_MemRead,
    input  logic [1:0]                EX_BranchType,
    output logic [1:0]                MEM_BranchType,
    input  logic [1:0]                EX_DBDataSrc,
    output logic [1:0]                MEM_DBDataSrc,
    input  logic                      EX_RegWre,
    output logic                      MEM_RegWre,
    input  logic [DATA_WIDTH-1:0]     EX_PCadd4,
    output logic [DATA_WIDTH-1:0]     MEM_PCadd4,
    input  logic [DATA_WIDTH-1:0]     EX_BranchPC,
    output logic [DATA_WIDTH-1:0]     MEM_BranchPC,
    input  logic                      EX_Zero,
    output logic                      MEM_Zero,
    input  logic                      EX_Sign,
    output logic                      MEM_Sign,
    input  logic [DATA_WIDTH-1:0]     EX_DataIn,
    output logic [DATA_WIDTH-1:0]     MEM_DataIn,
    input  logic [DATA_WIDTH-1:0]     EX_ALUResult,
    output logic [DATA_WIDTH-1:0]     MEM_ALUResult,
    input  logic [REG_ADDR_WIDTH-1:0] EX_WriteReg,
    output logic [REG_ADDR_WIDTH-1:0] MEM_WriteReg
);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset || EX_MEM_Flush) begin
            // Reset is asynchronous; flush only acts on a clock edge.
            MEM_MemWre     <= 1'b0;
            MEM_MemRead    <= 1'b0;
            MEM_BranchType <= 2'b00;
            MEM_DBDataSrc  <= 2'b00;
            MEM_RegWre     <= 1'b0;
            MEM_PCadd4     <= '0;
            MEM_BranchPC   <= '0;
            MEM_Zero       <= 1'b0;
            MEM_Sign       <= 1'b0;
            MEM_DataIn     <= '0;
            MEM_ALUResult  <= '0;
            MEM_WriteReg   <= '0;
        end else if (!EX_MEM_Stall) begin
            MEM_MemWre     <= EX_MemWre;
            MEM_MemRead    <= EX_MemRead;
            MEM_BranchType <= EX_BranchType;
            MEM_DBDataSrc  <= EX_DBDataSrc;
            MEM_RegWre     <= EX_RegWre;
            MEM_PCadd4     <= EX_PCadd4;
            MEM_BranchPC   <= EX_BranchPC;
            MEM_Zero       <= EX_Zero;
            MEM_Sign       <= EX_Sign;
            MEM_DataIn     <= EX_DataIn;
            MEM_ALUResult  <= EX_ALUResult;
            MEM_WriteReg   <= EX_WriteReg;
        end
    end

endmodule

// File: tb/tb_ex_mem_pipeline_register.sv
// Randomized bench for ex_mem_pipeline_register: a behavioural model is compared on every
// falling edge, plus directed checks with hand-computed literal expectations.
module tb_ex_mem_pipeline_register;

    localparam int W = 142;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        EX_MEM_Flush = 1'b0, EX_MEM_Stall = 1'b0;
    logic        EX_MemWre = 1'b0, EX_MemRead = 1'b0, EX_RegWre = 1'b0;
    logic        EX_Zero = 1'b0, EX_Sign = 1'b0;
    logic [1:0]  EX_BranchType = 2'b0, EX_DBDataSrc = 2'b0;
    logic [31:0] EX_PCadd4 = '0, EX_BranchPC = '0, EX_DataIn = '0, EX_ALUResult = '0;
    logic [4:0]  EX_WriteReg = '0;
    logic        MEM_MemWre, MEM_MemRead, MEM_RegWre, MEM_Zero, MEM_Sign;
    logic [1:0]  MEM_BranchType, MEM_DBDataSrc;
    logic [31:0] MEM_PCadd4, MEM_BranchPC, MEM_DataIn, MEM_ALUResult;
    logic [4:0]  MEM_WriteReg;

    int nCompared = 0;
    int nFailed = 0;
    logic cmpEn = 1'b0;
    logic [W-1:0] model = '0;
    logic [W-1:0] expLoad;

    ex_mem_pipeline_register #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .Clk(Clk), .Reset(Reset), .EX_MEM_Flush(EX_MEM_Flush), .EX_MEM_Stall(EX_MEM_Stall),
        .EX_MemWre(EX_MemWre), .MEM_MemWre(MEM_MemWre),
        .EX_MemRead(EX_MemRead), .MEM_MemRead(MEM_MemRead),
        .EX_BranchType(EX_BranchType), .MEM_BranchType(MEM_BranchType),
        .EX_DBDataSrc(EX_DBDataSrc), .MEM_DBDataSrc(MEM_DBDataSrc),
        .EX_RegWre(EX_RegWre), .MEM_RegWre(MEM_RegWre),
        .EX_PCadd4(EX_PCadd4), .MEM_PCadd4(MEM_PCadd4),
        .EX_BranchPC(EX_BranchPC), .MEM_BranchPC(MEM_BranchPC),
        .EX_Zero(EX_Zero), .MEM_Zero(MEM_Zero),
        .EX_Sign(EX_Sign), .MEM_Sign(MEM_Sign),
        .EX_DataIn(EX_DataIn), .MEM_DataIn(MEM_DataIn),
        .EX_ALUResult(EX_ALUResult), .MEM_ALUResult(MEM_ALUResult),
        .EX_WriteReg(EX_WriteReg), .MEM_WriteReg(MEM_WriteReg)
    );

    always #5 Clk = ~Clk;

    function automatic logic [W-1:0] inPack();
        return {EX_MemWre, EX_MemRead, EX_BranchType, EX_DBDataSrc, EX_RegWre, EX_PCadd4,
                EX_BranchPC, EX_Zero, EX_Sign, EX_DataIn, EX_ALUResult, EX_WriteReg};
    endfunction

    function automatic logic [W-1:0] outPack();
        return {MEM_MemWre, MEM_MemRead, MEM_BranchType, MEM_DBDataSrc, MEM_RegWre, MEM_PCadd4,
                MEM_BranchPC, MEM_Zero, MEM_Sign, MEM_DataIn, MEM_ALUResult, MEM_WriteReg};
    endfunction

    // Reference: the MEM side is simply what the EX side was at the last accepted edge.
    always @(posedge Clk or negedge Reset) begin
        if (!Reset) model = '0;
        else if (EX_MEM_Flush) model = '0;
        else if (!EX_MEM_Stall) model = inPack();
    end

    always @(negedge Clk) begin
        if (cmpEn) begin
            nCompared++;
            if (outPack() !== model) begin
                nFailed++;
                $display("FAIL model t=%0t got=%h want=%h", $time, outPack(), model);
            end
        end
    end

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        nCompared++;
        if (got !== want) begin
            nFailed++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic randomInputs();
        EX_MemWre     = 1'($urandom);
        EX_MemRead    = 1'($urandom);
        EX_BranchType = 2'($urandom);
        EX_DBDataSrc  = 2'($urandom);
        EX_RegWre     = 1'($urandom);
        EX_PCadd4     = $urandom;
        EX_BranchPC   = $urandom;
        EX_Zero       = 1'($urandom);
        EX_Sign       = 1'($urandom);
        EX_DataIn     = $urandom;
        EX_ALUResult  = $urandom;
        EX_WriteReg   = 5'($urandom);
    endtask

    initial begin
        #1 Reset = 1'b0;
        #1 cmpEn = 1'b1;
        randomInputs();
        check("reset_hold", outPack(), '0);
        tick();
        check("reset_after_edge", outPack(), '0);
        @(negedge Clk);
        #1 Reset = 1'b1;
        #1 check("reset_released_no_edge", outPack(), '0);

        @(posedge Clk);
        #1;
        EX_MemWre = 1; EX_MemRead = 1; EX_BranchType = 2'b01; EX_DBDataSrc = 2'd2;
        EX_RegWre = 1; EX_PCadd4 = 32'h1234_0000; EX_BranchPC = 32'h1234_5678;
        EX_Zero = 1; EX_Sign = 0; EX_DataIn = 32'h0000_0ABC; EX_ALUResult = 32'h00C0_FFEE;
        EX_WriteReg = 5'd1;
        expLoad = {1'b1, 1'b1, 2'b01, 2'b10, 1'b1, 32'h1234_0000, 32'h1234_5678, 1'b1, 1'b0,
                   32'h0000_0ABC, 32'h00C0_FFEE, 5'd1};
        tick();
        check("load", outPack(), expLoad);

        EX_MEM_Flush = 1;
        tick();
        check("flush", outPack(), '0);
        EX_MEM_Flush = 0;
        tick();
        check("reload_alu", {110'b0, MEM_ALUResult}, {110'b0, 32'h00C0_FFEE});
        check("reload_wreg", {137'b0, MEM_WriteReg}, {137'b0, 5'd1});

        EX_MEM_Stall = 1;
        EX_ALUResult = 32'hDEAD_BEEF;
        tick();
        check("stall_1", {110'b0, MEM_ALUResult}, {110'b0, 32'h00C0_FFEE});
        tick();
        check("stall_2", outPack(), expLoad);
        EX_MEM_Stall = 0;
        tick();
        check("unstall", {110'b0, MEM_ALUResult}, {110'b0, 32'hDEAD_BEEF});

        EX_MEM_Flush = 1;
        EX_MEM_Stall = 1;
        tick();
        check("flush_over_stall", outPack(), '0);
        EX_MEM_Flush = 0;
        EX_MEM_Stall = 0;
        EX_ALUResult = 32'h00C0_FFEE;
        tick();
        check("load_again", outPack(), expLoad);

        #1 Reset = 1'b0;
        #1 check("async_reset", outPack(), '0);
        Reset = 1'b1;
        #1 check("async_reset_release", outPack(), '0);
        tick();
        check("load_after_reset", outPack(), expLoad);

        for (int i = 0; i < 400; i++) begin
            randomInputs();
            EX_MEM_Flush = ($urandom_range(0, 9) == 0);
            EX_MEM_Stall = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 39) == 0) begin
                Reset = 1'b0;
                #1 check("rand_async_reset", outPack(), '0);
                Reset = 1'b1;
            end
            tick();
        end

        @(negedge Clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nFailed);
        $finish;
    end

endmodule

// File: doc/ex_mem_pipeline_register.md
Name: ex_mem_pipeline_register

Overview:
Pipeline register between the EX and MEM stages of the 5-stage pipelined CPU. It captures EX-stage control signals (MEM and WB groups) and datapath values on each rising clock edge and presents them to the MEM stage. A synchronous flush converts the captured instruction into a bubble for branch resolution, and a stall input holds the current contents.

Parameters:
DATA_WIDTH, 32, width of the PC, branch target, store data and ALU result buses
REG_ADDR_WIDTH, 5, width of the destination register index

Ports:
Clk  input  1  pipeline clock, rising-edge active
Reset  input  1  asynchronous, active-low reset
EX_MEM_Flush  input  1  synchronous flush; loads a bubble (all zeros)
EX_MEM_Stall  input  1  synchronous hold; keeps current contents
EX_MemWre  input  1  data-memory write enable from EX
MEM_MemWre  output  1  registered EX_MemWre
EX_MemRead  input  1  data-memory read enable
MEM_MemRead  output  1  registered EX_MemRead
EX_BranchType  input  2  branch kind code
MEM_BranchType  output  2  registered EX_BranchType
EX_DBDataSrc  input  2  write-back data source select
MEM_DBDataSrc  output  2  registered EX_DBDataSrc
EX_RegWre  input  1  register-file write enable
MEM_RegWre  output  1  registered EX_RegWre
EX_PCadd4  input  DATA_WIDTH  PC+4 of the instruction
MEM_PCadd4  output  DATA_WIDTH  registered EX_PCadd4
EX_BranchPC  input  DATA_WIDTH  computed branch target
MEM_BranchPC  output  DATA_WIDTH  registered EX_BranchPC
EX_Zero  input  1  ALU zero flag
MEM_Zero  output  1  registered EX_Zero
EX_Sign  input  1  ALU sign flag
MEM_Sign  output  1  registered EX_Sign
EX_DataIn  input  DATA_WIDTH  store data (rt value)
MEM_DataIn  output  DATA_WIDTH  registered EX_DataIn
EX_ALUResult  input  DATA_WIDTH  ALU result or memory address
MEM_ALUResult  output  DATA_WIDTH  registered EX_ALUResult
EX_WriteReg  input  REG_ADDR_WIDTH  destination register index
MEM_WriteReg  output  REG_ADDR_WIDTH  registered EX_WriteReg

Behaviour:
- All outputs are registers; there is no combinational path from input to output. Latency is exactly 1 clock edge.
- Reset low, asynchronous: all outputs are forced to 0 immediately, independent of Clk, and held at 0 while Reset is low. The first capture happens on the first rising edge after Reset goes high.
- Priority on each rising Clk edge with Reset high: Flush, then Stall, then normal load.
- EX_MEM_Flush=1: every output becomes 0 on that edge, control and datapath alike. The result is a NOP bubble: MemWre=0, MemRead=0, RegWre=0, BranchType=00.
- EX_MEM_Flush=0 and EX_MEM_Stall=1: every output keeps its previous value.
- Both 0: every MEM_x output takes the value of EX_x sampled at the edge.
- Flush and Stall both 1: Flush wins and outputs clear.
- Input changes between edges have no effect on the outputs.
- Reset asserted mid-cycle overrides any pending flush, stall or load.
- No width conversion. Each field is copied bit-exact with no sign or zero extension.

Test Plan:
- Reset: hold Reset=0 with arbitrary inputs, including one Clk edge -> all outputs 0 throughout. Release Reset -> outputs still 0 until the next rising edge.
- Normal load: Reset=1, Flush=0, Stall=0; inputs MemWre=1, MemRead=1, BranchType=01, DBDataSrc=2, RegWre=1, PCadd4=0x12340000, BranchPC=0x12345678, Zero=1, Sign=0, DataIn=0xABC, ALUResult=0xC0FFEE, WriteReg=1; apply one rising edge -> every output equals its input.
- Flush: from the loaded state, set Flush=1 and apply an edge -> all outputs 0. Set Flush=0 and apply the next edge -> values reload (MEM_ALUResult=0xC0FFEE, MEM_WriteReg=1).
- Stall: from the loaded state, set Stall=1, change inputs (ALUResult=0xDEADBEEF) and apply two edges -> MEM_ALUResult stays 0xC0FFEE. Release Stall -> 0xDEADBEEF appears after one edge.
- Flush+Stall together on an edge -> all outputs 0.
- Async reset mid-cycle: from the loaded state, pulse Reset low between edges -> outputs 0 before the next edge, with no wait for Clk.
